// File: rtl/frame_pkg.sv
// Shared types and constants for the frame arbiter: FSM encoding, frame-index field
// position and default hold limit.
package frame_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StGntLe = 3'd1,
        StGntFl = 3'd2,
        StDrain = 3'd3,
        StSwap  = 3'd4
    } state_e;

    typedef enum logic {
        OwnLe = 1'b0,
        OwnFl = 1'b1
    } owner_e;

    localparam int unsigned DefaultMaxHold = 1024;
    localparam int unsigned DefaultCntW    = 11;

    localparam int unsigned IdxMsb    = 24;
    localparam int unsigned IdxLsb    = 19;
    localparam int unsigned IdxShift  = 3;
    localparam int unsigned FrameIdxW = IdxMsb - IdxLsb + 1;

    // Field is FrameWrData[IdxMsb:IdxLsb]; the low bits are sub-frame granularity.
    function automatic logic [FrameIdxW-1:0] frame_index(input logic [FrameIdxW-1:0] field);
        return field >> IdxShift;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with a last-served register; the pick is combinational and
// the register advances only when the caller accepts the pick.
module rr_arbiter2
    import frame_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_le_i,
    input  logic req_fl_i,
    input  logic accept_i,
    output logic pick_le_o,
    output logic pick_fl_o
);

    owner_e last_q;

    // On contention the requester that was not served last wins.
    always_comb begin
        pick_le_o = req_le_i & (~req_fl_i | (last_q == OwnFl));
        pick_fl_o = req_fl_i & (~req_le_i | (last_q == OwnLe));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= OwnFl;
        end else if (accept_i && (pick_le_o || pick_fl_o)) begin
            last_q <= pick_fl_o ? OwnFl : OwnLe;
        end
    end

endmodule

// File: rtl/frame_arbiter.sv
// Bus arbiter between line engine and filler that also applies CPU frame-base swaps
// at vertical blank, draining any in-flight burst first.
module frame_arbiter
    import frame_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DefaultMaxHold,
    parameter int unsigned CNT_W    = DefaultCntW
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 FrameWrValid,
    input  logic [31:0]          FrameWrData,
    input  logic                 VSync,
    input  logic                 LEReq,
    input  logic                 FLReq,
    input  logic                 LEDone,
    input  logic                 FLDone,
    output logic                 LEGrant,
    output logic                 FLGrant,
    output logic [FrameIdxW-1:0] FrameIdx,
    output logic                 SwapPending,
    output logic                 SwapDone,
    input  logic                 ErrClr,
    output logic                 TimeoutErr
);

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    state_e                 state_q;
    logic [FrameIdxW-1:0]   pend_idx_q;
    logic                   armed_q;
    logic [CNT_W-1:0]       hold_cnt_q;

    logic [FrameIdxW-1:0]   wr_idx;
    logic [FrameIdxW-1:0]   idx_next;
    logic                   granted;
    logic                   owner_done;
    logic                   hold_expired;
    logic                   release_now;
    logic                   arm_hit;
    logic                   swap_req;
    logic                   busy;
    logic                   idle_grant;
    logic                   swap_enter;
    logic                   pick_le;
    logic                   pick_fl;
    logic                   unused_wr_bits;

    assign unused_wr_bits = ^{FrameWrData[31:IdxMsb+1], FrameWrData[IdxLsb-1:0]};

    always_comb begin
        wr_idx       = frame_index(FrameWrData[IdxMsb:IdxLsb]);
        idx_next     = FrameWrValid ? wr_idx : pend_idx_q;
        granted      = LEGrant | FLGrant;
        owner_done   = (LEGrant & LEDone) | (FLGrant & FLDone);
        hold_expired = granted & (hold_cnt_q >= HoldLast) & ~owner_done;
        release_now  = owner_done | hold_expired;
        // A write landing in the SWAP cycle becomes pending but is not armed.
        arm_hit      = VSync & (SwapPending | FrameWrValid) & (state_q != StSwap);
        swap_req     = armed_q | arm_hit;
        busy         = (state_q == StGntLe) | (state_q == StGntFl) | (state_q == StDrain);
        idle_grant   = (state_q == StIdle) & ~swap_req & (LEReq | FLReq);
        swap_enter   = ((state_q == StIdle) & swap_req) | (busy & release_now & swap_req);
    end

    rr_arbiter2 u_rr (
        .clk_i     (Clock),
        .rst_ni    (Reset),
        .req_le_i  (LEReq),
        .req_fl_i  (FLReq),
        .accept_i  (idle_grant),
        .pick_le_o (pick_le),
        .pick_fl_o (pick_fl)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            LEGrant     <= 1'b0;
            FLGrant     <= 1'b0;
            FrameIdx    <= '0;
            pend_idx_q  <= '0;
            SwapPending <= 1'b0;
            armed_q     <= 1'b0;
            SwapDone    <= 1'b0;
            TimeoutErr  <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            // The new index becomes visible in the SWAP cycle itself.
            if (swap_enter) begin
                FrameIdx    <= idx_next;
                pend_idx_q  <= idx_next;
                SwapPending <= 1'b0;
                armed_q     <= 1'b0;
            end else begin
                if (FrameWrValid) begin
                    pend_idx_q  <= wr_idx;
                    SwapPending <= 1'b1;
                end
                if (arm_hit) begin
                    armed_q <= 1'b1;
                end
            end

            SwapDone <= (state_q == StSwap);

            if (hold_expired) begin
                TimeoutErr <= 1'b1;
            end else if (ErrClr) begin
                TimeoutErr <= 1'b0;
            end

            if (idle_grant) begin
                hold_cnt_q <= '0;
            end else if (granted) begin
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            end

            case (state_q)
                StIdle: begin
                    if (swap_req) begin
                        state_q <= StSwap;
                    end else if (pick_le) begin
                        state_q <= StGntLe;
                        LEGrant <= 1'b1;
                    end else if (pick_fl) begin
                        state_q <= StGntFl;
                        FLGrant <= 1'b1;
                    end
                end
                StGntLe, StGntFl: begin
                    if (release_now) begin
                        LEGrant <= 1'b0;
                        FLGrant <= 1'b0;
                        state_q <= swap_req ? StSwap : StIdle;
                    end else if (swap_req) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (release_now) begin
                        LEGrant <= 1'b0;
                        FLGrant <= 1'b0;
                        state_q <= StSwap;
                    end
                end
                StSwap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    LEGrant <= 1'b0;
                    FLGrant <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter: round-robin bursts, frame swaps, drain, timeout, reset.
module tb_frame_arbiter;

    logic        Clock;
    logic        Reset;
    logic        FrameWrValid;
    logic [31:0] FrameWrData;
    logic        VSync;
    logic        LEReq;
    logic        FLReq;
    logic        LEDone;
    logic        FLDone;
    logic        LEGrant;
    logic        FLGrant;
    logic [5:0]  FrameIdx;
    logic        SwapPending;
    logic        SwapDone;
    logic        ErrClr;
    logic        TimeoutErr;

    int checks = 0;
    int errors = 0;

    frame_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .FrameWrValid (FrameWrValid),
        .FrameWrData  (FrameWrData),
        .VSync        (VSync),
        .LEReq        (LEReq),
        .FLReq        (FLReq),
        .LEDone       (LEDone),
        .FLDone       (FLDone),
        .LEGrant      (LEGrant),
        .FLGrant      (FLGrant),
        .FrameIdx     (FrameIdx),
        .SwapPending  (SwapPending),
        .SwapDone     (SwapDone),
        .ErrClr       (ErrClr),
        .TimeoutErr   (TimeoutErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        assert (!(LEGrant && FLGrant)) else begin
            errors++;
            $error("FAIL %s_exclusive observed=11 expected=not both", tag);
        end
    endtask

    // Entered with the owner's grant already visible (cycle 1); Done is pulsed in the
    // last cycle so the grant is high for exactly `cycles` cycles.
    task automatic burst(input bit le, input int cycles, input bit poke);
        for (int i = 1; i < cycles; i++) begin
            if (poke && i == 2) begin
                if (le) FLDone = 1'b1;
                else    LEDone = 1'b1;
            end
            step();
            LEDone = 1'b0;
            FLDone = 1'b0;
            check("burst_held", {30'b0, LEGrant, FLGrant}, le ? 32'd2 : 32'd1);
        end
        if (le) LEDone = 1'b1;
        else    FLDone = 1'b1;
        step();
        LEDone = 1'b0;
        FLDone = 1'b0;
        check("burst_release", {30'b0, LEGrant, FLGrant}, 32'd0);
    endtask

    initial begin
        Reset        = 1'b0;
        FrameWrValid = 1'b0;
        FrameWrData  = '0;
        VSync        = 1'b0;
        LEReq        = 1'b0;
        FLReq        = 1'b0;
        LEDone       = 1'b0;
        FLDone       = 1'b0;
        ErrClr       = 1'b0;

        #1;
        check("rst_grants", {30'b0, LEGrant, FLGrant}, 32'd0);
        check("rst_idx", {26'b0, FrameIdx}, 32'd0);
        check("rst_flags", {29'b0, SwapPending, SwapDone, TimeoutErr}, 32'd0);
        step();
        step();
        Reset = 1'b1;

        // Round robin with both requesting: LE, FL, LE, one idle cycle between.
        step();
        LEReq = 1'b1;
        FLReq = 1'b1;
        step();
        check("rr_first_le", {30'b0, LEGrant, FLGrant}, 32'd2);
        burst(1'b1, 4, 1'b0);
        step();
        check("rr_second_fl", {30'b0, LEGrant, FLGrant}, 32'd1);
        burst(1'b0, 4, 1'b1);
        step();
        check("rr_third_le", {30'b0, LEGrant, FLGrant}, 32'd2);
        burst(1'b1, 4, 1'b0);
        LEReq = 1'b0;
        FLReq = 1'b0;
        step();
        check("rr_quiet", {30'b0, LEGrant, FLGrant}, 32'd0);

        // Swap in IDLE: index 2 in the cycle after VSync, SwapDone one cycle later.
        FrameWrValid = 1'b1;
        FrameWrData  = 32'h1080_0000;
        step();
        FrameWrValid = 1'b0;
        check("idle_pending", {31'b0, SwapPending}, 32'd1);
        check("idle_idx_old", {26'b0, FrameIdx}, 32'd0);
        VSync = 1'b1;
        step();
        VSync = 1'b0;
        check("idle_idx_new", {26'b0, FrameIdx}, 32'd2);
        check("idle_swap_cycle", {28'b0, SwapPending, SwapDone, LEGrant, FLGrant}, 32'd0);
        step();
        check("idle_swapdone", {31'b0, SwapDone}, 32'd1);
        step();
        check("idle_swapdone_pulse", {31'b0, SwapDone}, 32'd0);

        // Swap armed mid-burst: LE drains, FL waits, then FL is served after the swap.
        LEReq = 1'b1;
        step();
        check("drain_le_grant", {30'b0, LEGrant, FLGrant}, 32'd2);
        LEReq = 1'b0;
        FLReq = 1'b1;
        step();
        check("drain_req_drop_held", {30'b0, LEGrant, FLGrant}, 32'd2);
        FrameWrValid = 1'b1;
        FrameWrData  = 32'h00C0_0000;
        VSync        = 1'b1;
        step();
        FrameWrValid = 1'b0;
        VSync        = 1'b0;
        check("drain_held", {30'b0, LEGrant, FLGrant}, 32'd2);
        check("drain_pending", {31'b0, SwapPending}, 32'd1);
        check("drain_idx_old", {26'b0, FrameIdx}, 32'd2);
        FLDone = 1'b1;
        step();
        FLDone = 1'b0;
        check("drain_foreign_done", {30'b0, LEGrant, FLGrant}, 32'd2);
        step();
        check("drain_no_fl", {30'b0, LEGrant, FLGrant}, 32'd2);
        LEDone = 1'b1;
        step();
        LEDone = 1'b0;
        check("drain_swap_grants", {30'b0, LEGrant, FLGrant}, 32'd0);
        check("drain_idx_new", {26'b0, FrameIdx}, 32'd3);
        check("drain_pending_clr", {31'b0, SwapPending}, 32'd0);
        step();
        check("drain_swapdone", {29'b0, SwapDone, LEGrant, FLGrant}, 32'd4);
        step();
        check("drain_fl_after", {30'b0, LEGrant, FLGrant}, 32'd1);

        // Hold timeout: FL keeps the bus 8 cycles without Done, then LE is served.
        LEReq = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            step();
            check("to_held", {30'b0, LEGrant, FLGrant}, 32'd1);
        end
        check("to_not_yet", {31'b0, TimeoutErr}, 32'd0);
        step();
        check("to_drop", {30'b0, LEGrant, FLGrant}, 32'd0);
        check("to_err_set", {31'b0, TimeoutErr}, 32'd1);
        step();
        check("to_le_next", {30'b0, LEGrant, FLGrant}, 32'd2);
        check("to_err_sticky", {31'b0, TimeoutErr}, 32'd1);
        ErrClr = 1'b1;
        step();
        ErrClr = 1'b0;
        check("to_err_clr", {31'b0, TimeoutErr}, 32'd0);
        LEReq  = 1'b0;
        FLReq  = 1'b0;
        LEDone = 1'b1;
        step();
        LEDone = 1'b0;
        check("to_le_release", {30'b0, LEGrant, FLGrant}, 32'd0);

        // Two writes before VSync: only the last one is applied.
        FrameWrValid = 1'b1;
        FrameWrData  = 32'h1080_0000;
        step();
        FrameWrData  = 32'h01C0_0000;
        step();
        FrameWrValid = 1'b0;
        check("ow_idx_old", {26'b0, FrameIdx}, 32'd3);
        VSync = 1'b1;
        step();
        VSync = 1'b0;
        check("ow_idx_new", {26'b0, FrameIdx}, 32'd7);
        // Write plus VSync during the SWAP cycle: pending, but not armed.
        FrameWrValid = 1'b1;
        FrameWrData  = 32'h00C0_0000;
        VSync        = 1'b1;
        step();
        FrameWrValid = 1'b0;
        VSync        = 1'b0;
        check("swapwr_flags", {30'b0, SwapPending, SwapDone}, 32'd3);
        step();
        check("swapwr_not_armed", {26'b0, FrameIdx}, 32'd7);
        step();
        check("swapwr_still_pending", {31'b0, SwapPending}, 32'd1);

        // Asynchronous reset mid-burst with a swap pending.
        LEReq = 1'b1;
        step();
        check("ar_le_grant", {30'b0, LEGrant, FLGrant}, 32'd2);
        #2;
        Reset = 1'b0;
        #1;
        check("ar_grants_async", {30'b0, LEGrant, FLGrant}, 32'd0);
        step();
        Reset = 1'b1;
        LEReq = 1'b0;
        step();
        check("ar_pending", {31'b0, SwapPending}, 32'd0);
        check("ar_idx", {26'b0, FrameIdx}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
